// File: rtl/match_score_scheduler_pkg.sv
// rtl/match_score_scheduler_pkg.sv - shared defaults and FSM encoding for the match score scheduler
package match_score_scheduler_pkg;
  localparam int NUM_CH_DEF  = 4;
  localparam int SCORE_W_DEF = 8;
  localparam int THRESH_DEF  = 10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SERVE = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;
endpackage

// File: rtl/match_score_scheduler_rr_pick.sv
// rtl/match_score_scheduler_rr_pick.sv - combinational round-robin picker
// Winner is the first set Pending bit found searching upward from Ptr, wrapping.
module rr_pick
  import match_score_scheduler_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int PTR_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] Pending,
  input  logic [PTR_W-1:0]  Ptr,
  output logic [NUM_CH-1:0] Winner,
  output logic              Any
);
  logic [PTR_W-1:0] idx;

  always_comb begin
    Winner = '0;
    Any    = 1'b0;
    idx    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = PTR_W'((int'(Ptr) + i) % NUM_CH);
      if (!Any && Pending[idx]) begin
        Any         = 1'b1;
        Winner[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/match_score_scheduler.sv
// rtl/match_score_scheduler.sv - round-robin match scheduler with saturating score
// Pending match pulses are granted one channel per cycle; each grant adds one to Score.
module match_score_scheduler
  import match_score_scheduler_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int SCORE_W = SCORE_W_DEF,
  parameter int THRESH  = THRESH_DEF
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [NUM_CH-1:0]  Match_Pulse,
  input  logic               Clear,
  output logic [NUM_CH-1:0]  Grant,
  output logic               Grant_Valid,
  output logic [SCORE_W-1:0] Score,
  output logic               Hit,
  output logic               Overflow_Err
);
  localparam int PTR_W = $clog2(NUM_CH);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  logic [1:0]         state_q, state_d;
  logic [NUM_CH-1:0]  pending_q, pending_d;
  logic [NUM_CH-1:0]  grant_q, grant_d;
  logic               grant_valid_q, grant_valid_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               hit_q, hit_d;
  logic               ovf_q, ovf_d;

  logic [PTR_W-1:0]   ptr_after;
  logic [PTR_W-1:0]   pick_ptr;
  logic [NUM_CH-1:0]  pick_req;
  logic [NUM_CH-1:0]  pick_winner;
  logic               pick_any;

  // Pointer value that follows the channel being granted this cycle.
  always_comb begin
    ptr_after = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_q[i]) ptr_after = (i == NUM_CH - 1) ? '0 : PTR_W'(i + 1);
    end
  end

  // While serving, the next winner may come from pulses landing this cycle.
  always_comb begin
    if (state_q == ST_SERVE) begin
      pick_req = (pending_q | Match_Pulse) & ~grant_q;
      pick_ptr = ptr_after;
    end else begin
      pick_req = pending_q;
      pick_ptr = ptr_q;
    end
  end

  rr_pick #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_rr_pick (
    .Pending (pick_req),
    .Ptr     (pick_ptr),
    .Winner  (pick_winner),
    .Any     (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    ptr_d     = ptr_q;
    score_d   = score_q;
    ovf_d     = ovf_q;
    grant_d   = '0;
    if (state_q == ST_CLEAR) begin
      pending_d = '0;
      ptr_d     = '0;
      score_d   = '0;
      ovf_d     = 1'b0;
      state_d   = Clear ? ST_CLEAR : ST_IDLE;
    end else if (Clear) begin
      state_d = ST_CLEAR;
    end else begin
      pending_d = (pending_q & ~grant_q) | Match_Pulse;
      if (|(Match_Pulse & pending_q & ~grant_q)) ovf_d = 1'b1;
      if (state_q == ST_SERVE) begin
        ptr_d = ptr_after;
        if (score_q != SCORE_MAX) score_d = score_q + 1'b1;
      end
      if (pick_any) begin
        grant_d = pick_winner;
        state_d = ST_SERVE;
      end else begin
        state_d = ST_IDLE;
      end
    end
    grant_valid_d = |grant_d;
    hit_d         = (state_q != ST_CLEAR) && (32'(score_d) >= 32'(THRESH));
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q       <= ST_IDLE;
      pending_q     <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      ptr_q         <= '0;
      score_q       <= '0;
      hit_q         <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      ptr_q         <= ptr_d;
      score_q       <= score_d;
      hit_q         <= hit_d;
      ovf_q         <= ovf_d;
    end
  end

  assign Grant        = grant_q;
  assign Grant_Valid  = grant_valid_q;
  assign Score        = score_q;
  assign Hit          = hit_q;
  assign Overflow_Err = ovf_q;
endmodule

// File: tb/tb_match_score_scheduler.sv
// tb/tb_match_score_scheduler.sv - self-checking bench for match_score_scheduler
// Two instances (8-bit and 4-bit score) share stimulus and are compared to one reference model.
module tb_match_score_scheduler;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] pulse = 4'd0;
  logic       clear = 1'b0;

  logic [3:0] g1, g2;
  logic       gv1, gv2, h1, h2, o1, o2;
  logic [7:0] s1;
  logic [3:0] s2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  match_score_scheduler dut8 (
    .Clk(clk), .Rst(rst), .Match_Pulse(pulse), .Clear(clear),
    .Grant(g1), .Grant_Valid(gv1), .Score(s1), .Hit(h1), .Overflow_Err(o1)
  );

  match_score_scheduler #(.NUM_CH(4), .SCORE_W(4), .THRESH(10)) dut4 (
    .Clk(clk), .Rst(rst), .Match_Pulse(pulse), .Clear(clear),
    .Grant(g2), .Grant_Valid(gv2), .Score(s2), .Hit(h2), .Overflow_Err(o2)
  );

  wire [14:0] obs1 = {g1, gv1, s1, h1, o1};
  wire [10:0] obs2 = {g2, gv2, s2, h2, o2};

  // Reference model: pending events per channel, a rotating pointer, the channel on
  // the grant output (-1 when none) and two saturating score counters.
  bit m_pend[4];
  int m_ptr;
  int m_grant;
  bit m_clearing;
  int m_score1;
  int m_score2;
  bit m_ovf;

  function automatic void model_reset();
    m_pend     = '{default: 1'b0};
    m_ptr      = 0;
    m_grant    = -1;
    m_clearing = 1'b0;
    m_score1   = 0;
    m_score2   = 0;
    m_ovf      = 1'b0;
  endfunction

  function automatic void model_step(input logic [3:0] p, input bit clr);
    int served;
    int nxt;
    bit cand[4];
    if (m_clearing) begin
      model_reset();
      m_clearing = clr;
      return;
    end
    if (clr) begin
      m_clearing = 1'b1;
      m_grant    = -1;
      return;
    end
    served = m_grant;
    for (int i = 0; i < 4; i++) begin
      cand[i] = (m_pend[i] || (served >= 0 && p[i] == 1'b1)) && i != served;
      if (p[i] == 1'b1 && m_pend[i] && i != served) m_ovf = 1'b1;
    end
    for (int i = 0; i < 4; i++) m_pend[i] = (m_pend[i] && i != served) || p[i] == 1'b1;
    if (served >= 0) begin
      m_ptr    = (served + 1) % 4;
      m_score1 = (m_score1 < 255) ? m_score1 + 1 : 255;
      m_score2 = (m_score2 < 15) ? m_score2 + 1 : 15;
    end
    nxt = -1;
    for (int k = 0; k < 4; k++) begin
      if (nxt < 0 && cand[(m_ptr + k) % 4]) nxt = (m_ptr + k) % 4;
    end
    m_grant = nxt;
  endfunction

  function automatic logic [3:0] m_gvec();
    return (m_grant >= 0) ? 4'(1 << m_grant) : 4'd0;
  endfunction

  function automatic logic [14:0] exp1();
    return {m_gvec(), m_grant >= 0, 8'(m_score1), m_score1 >= 10, m_ovf};
  endfunction

  function automatic logic [10:0] exp2();
    return {m_gvec(), m_grant >= 0, 4'(m_score2), m_score2 >= 10, m_ovf};
  endfunction

  task automatic step(input logic [3:0] p, input bit clr);
    @(negedge clk);
    pulse = p;
    clear = clr;
    @(posedge clk);
    model_step(p, clr);
    #1;
    pulse = 4'd0;
    clear = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    pulse = 4'd0;
    clear = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({obs1, obs2} !== 26'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h/%h want 0/0", obs1, obs2);
    end
    step(4'b0001, 1'b0);
    checks++;
    if (g1 !== 4'd0) begin
      errors++;
      $display("FAIL reset_early_grant got %b want 0000", g1);
    end
    step(4'b0000, 1'b0);
    checks++;
    if (g1 !== 4'b0001 || gv1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant got %b/%b want 0001/1", g1, gv1);
    end
    step(4'b0000, 1'b0);
  endtask

  task automatic test_single();
    do_reset();
    step(4'b0100, 1'b0);
    step(4'b0000, 1'b0);
    checks++;
    if (g1 !== 4'b0100 || gv1 !== 1'b1) begin
      errors++;
      $display("FAIL single_grant got %b/%b want 0100/1", g1, gv1);
    end
    step(4'b0000, 1'b0);
    checks++;
    if (s1 !== 8'd1 || h1 !== 1'b0 || g1 !== 4'd0 || gv1 !== 1'b0) begin
      errors++;
      $display("FAIL single_score got s=%0d h=%b g=%b want s=1 h=0 g=0000", s1, h1, g1);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] want;
    do_reset();
    step(4'b1111, 1'b0);
    for (int c = 0; c < 4; c++) begin
      step(4'b0000, 1'b0);
      want = 4'b0001 << c;
      checks++;
      if (g1 !== want || gv1 !== 1'b1) begin
        errors++;
        $display("FAIL b2b_grant%0d got %b want %b", c, g1, want);
      end
    end
    step(4'b0000, 1'b0);
    checks++;
    if (s1 !== 8'd4 || gv1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_score got %0d/%b want 4/0", s1, gv1);
    end
    // Pointer must have wrapped to 0, so ch0 wins over ch1 next.
    step(4'b0011, 1'b0);
    step(4'b0000, 1'b0);
    checks++;
    if (g1 !== 4'b0001) begin
      errors++;
      $display("FAIL b2b_ptr_wrap got %b want 0001", g1);
    end
    step(4'b0000, 1'b0);
    checks++;
    if (g1 !== 4'b0010) begin
      errors++;
      $display("FAIL b2b_second got %b want 0010", g1);
    end
    step(4'b0000, 1'b0);
  endtask

  task automatic test_hit();
    bit seen;
    seen = 1'b0;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      for (int c = 0; c < 4; c++) begin
        step((c == 0) ? 4'b0010 : 4'b0000, 1'b0);
        checks++;
        if (obs1 !== exp1()) begin
          errors++;
          $display("FAIL hit_model got %h want %h", obs1, exp1());
        end
        if (h1 === 1'b1 && !seen) begin
          seen = 1'b1;
          checks++;
          if (s1 !== 8'd10) begin
            errors++;
            $display("FAIL hit_rise_score got %0d want 10", s1);
          end
        end
      end
    end
    checks++;
    if (!seen || s1 !== 8'd12) begin
      errors++;
      $display("FAIL hit_final got seen=%b s=%0d want seen=1 s=12", seen, s1);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    step(4'b1001, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b0);
    for (int c = 0; c < 3; c++) step(4'b0000, 1'b0);
    checks++;
    if (o1 !== 1'b1 || s1 !== 8'd2) begin
      errors++;
      $display("FAIL overflow got ovf=%b s=%0d want ovf=1 s=2", o1, s1);
    end
  endtask

  task automatic test_saturate_clear();
    for (int k = 0; k < 20; k++) begin
      step(4'b0001, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);
      checks++;
      if (obs2 !== exp2()) begin
        errors++;
        $display("FAIL sat_model got %h want %h", obs2, exp2());
      end
    end
    checks++;
    if (s2 !== 4'd15 || s1 !== 8'd22) begin
      errors++;
      $display("FAIL sat_hold got %0d/%0d want 15/22", s2, s1);
    end
    step(4'b0001, 1'b1);
    step(4'b0001, 1'b0);
    checks++;
    if (s1 !== 8'd0 || o1 !== 1'b0 || h1 !== 1'b0 || g1 !== 4'd0) begin
      errors++;
      $display("FAIL clear_zero got s=%0d o=%b h=%b g=%b want 0", s1, o1, h1, g1);
    end
    step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    checks++;
    if (s2 !== 4'd1 || o2 !== 1'b0 || s1 !== 8'd1) begin
      errors++;
      $display("FAIL clear_then_pulse got %0d/%b/%0d want 1/0/1", s2, o2, s1);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);
    checks++;
    if (g1 !== 4'b0010) begin
      errors++;
      $display("FAIL rmid_grant got %b want 0010", g1);
    end
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({obs1, obs2} !== 26'd0) begin
      errors++;
      $display("FAIL rmid_async got %h/%h want 0/0", obs1, obs2);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) step(4'b0000, 1'b0);
    checks++;
    if (s1 !== 8'd0 || obs1 !== exp1()) begin
      errors++;
      $display("FAIL rmid_nocount got %h want %h", obs1, exp1());
    end
  endtask

  task automatic test_random();
    logic [3:0] p;
    bit         c;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 4; i++) p[i] = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 59) == 0);
      step(p, c);
      checks++;
      if (obs1 !== exp1() || obs2 !== exp2()) begin
        errors++;
        $display("FAIL random_cycle%0d got %h/%h want %h/%h", n, obs1, obs2, exp1(), exp2());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_hit();
    test_overflow();
    test_saturate_clear();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/match_score_scheduler.md
MATCH_SCORE_SCHEDULER -- requirements
Module: match_score_scheduler

Interface
REQ-001 Parameter NUM_CH, default 4: number of shaped match-pulse channels (2..8).
REQ-002 Parameter SCORE_W, default 8: score width in bits.
REQ-003 Parameter THRESH, default 10: score at or above which Hit asserts.
REQ-004 Clk  input  1  sole clock, rising edge.
REQ-005 Rst  input  1  asynchronous, active-high reset.
REQ-006 Match_Pulse  input  NUM_CH  one-cycle match pulses from the per-channel shapers.
REQ-007 Clear  input  1  synchronous score/pending clear request.
REQ-008 Grant  output  NUM_CH  one-hot channel currently being scored; zero when no grant.
REQ-009 Grant_Valid  output  1  high exactly when Grant is non-zero.
REQ-010 Score  output  SCORE_W  accumulated match count.
REQ-011 Hit  output  1  high while Score >= THRESH.
REQ-012 Overflow_Err  output  1  sticky flag: a match pulse was lost.

Function
REQ-013 Per-channel Pending bit SHALL set on the edge after its Match_Pulse is high, and clear on the edge ending that channel's grant cycle.
REQ-014 FSM states SHALL be IDLE, SERVE and CLEAR; all outputs registered.
REQ-015 IDLE: any Pending set -> SERVE; else stay IDLE; Grant = 0.
REQ-016 SERVE: Grant = one-hot winner; Grant_Valid = 1 for one cycle per winner; Score increments by 1 at the end of that cycle.
REQ-017 Winner SHALL be the first set Pending bit searching upward from round-robin pointer Ptr, wrapping modulo NUM_CH.
REQ-018 After each grant, Ptr SHALL become (winner+1) mod NUM_CH; Ptr resets to 0.
REQ-019 SERVE -> SERVE if any other Pending bit (excluding the winner) is set or arrives that cycle; else -> IDLE.
REQ-020 Latency: pulse in cycle n with FSM in IDLE and no contention -> Grant in cycle n+2 -> Score updated in cycle n+3.
REQ-021 Score SHALL saturate at 2^SCORE_W-1; further grants still occur but leave Score unchanged.
REQ-022 Hit SHALL update on the same edge as Score.
REQ-023 Pulse on a channel in the cycle that channel is granted: Pending stays set (new event), no error.
REQ-024 Pulse on a channel already Pending and not granted that cycle: Overflow_Err sets and stays set.
REQ-025 Clear high in any state -> CLEAR on next edge, with Grant = 0 immediately.
REQ-026 CLEAR: Score, Hit, Overflow_Err, Pending and Ptr zeroed, then -> IDLE.
REQ-027 Match_Pulse coinciding with Clear, or arriving in the CLEAR cycle, SHALL be discarded.

Reset
REQ-028 Rst high SHALL asynchronously force IDLE, with Pending = 0, Ptr = 0, Score = 0, Grant = 0, Grant_Valid = 0, Hit = 0, Overflow_Err = 0.
REQ-029 Reset asserted mid-SERVE SHALL drop the in-flight grant without incrementing Score.
REQ-030 First grant SHALL be possible no earlier than 2 cycles after Rst deassertion.

Structure
REQ-031 The FSM state encoding (IDLE=0, SERVE=1, CLEAR=2) and the NUM_CH/SCORE_W/THRESH defaults SHALL live in the shared scoreboard package.
REQ-032 Round-robin selection SHALL be a combinational sub-module rr_pick with inputs Pending and Ptr and outputs one-hot Winner and Any.

Verification
REQ-033 Single pulse on ch2 after reset -> Grant=4'b0100 two cycles later; Score=1 next cycle; Hit=0.
REQ-034 Simultaneous pulses on ch0..ch3 with Ptr=0 -> grants ch0,ch1,ch2,ch3 on consecutive cycles; Score=4; Ptr=0.
REQ-035 Twelve spaced pulses on ch1 -> Hit rises on the edge Score becomes 10; THRESH=10.
REQ-036 Pulse on ch3 twice while ch3 Pending (ch0 being served) -> Overflow_Err=1; Score +2 total, not +3.
REQ-037 SCORE_W=4, 20 pulses -> Score holds at 15 with no wrap; Clear then pulse on ch0 -> Score=1 and Overflow_Err=0.
REQ-038 Rst asserted during a ch1 grant -> all outputs 0 immediately; the ch1 match is not counted.
